// File: rtl/ahb_arbiter_param.sv
// Parametrised AHB2 bus arbiter: one-hot grant, registered address-phase owner and lock.
// Ownership never moves inside a fixed-length burst or a locked sequence. Priority is
// either fixed (index 0 highest) or round-robin.
module ahb_arbiter_param #(
  parameter int NUM_MASTERS    = 4,
  parameter int ARB_MODE       = 1,
  parameter int DEFAULT_MASTER = 0,
  parameter int HMASTER_W      = 4
) (
  input  logic                   hclk,
  input  logic                   hreset,
  input  logic [NUM_MASTERS-1:0] hbusreq,
  input  logic [NUM_MASTERS-1:0] hlock,
  input  logic [1:0]             htrans,
  input  logic [2:0]             hburst,
  input  logic                   hready,
  output logic [NUM_MASTERS-1:0] hgrant,
  output logic [HMASTER_W-1:0]   hmaster,
  output logic                   hmastlock
);

  localparam logic [1:0] TR_IDLE   = 2'd0;
  localparam logic [1:0] TR_BUSY   = 2'd1;
  localparam logic [1:0] TR_NONSEQ = 2'd2;
  localparam logic [1:0] TR_SEQ    = 2'd3;

  localparam logic [2:0] BU_SINGLE = 3'd0;
  localparam logic [2:0] BU_INCR   = 3'd1;

  localparam logic [HMASTER_W-1:0]   DEF_IDX   = HMASTER_W'(DEFAULT_MASTER);
  localparam logic [NUM_MASTERS-1:0] DEF_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;

  logic [4:0]             beat_cnt;
  logic [4:0]             beat_next;
  logic                   lock_hold;
  logic [HMASTER_W-1:0]   rr_ptr;
  logic [HMASTER_W-1:0]   grant_idx;
  logic [HMASTER_W-1:0]   winner;
  logic                   found;
  logic                   owner_lock;
  logic                   lock_active;
  logic                   burst_done;
  logic                   rearb_ok;
  logic                   any_req;

  // Binary index of the currently granted master (hgrant is one-hot)
  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (hgrant[i]) grant_idx = HMASTER_W'(i);
    end
  end

  assign owner_lock  = |(hlock & hgrant);
  assign lock_active = owner_lock | lock_hold;
  assign any_req     = |hbusreq;

  // Remaining-SEQ-beat count after the transfer currently presented is accepted
  always_comb begin
    beat_next = beat_cnt;
    case (htrans)
      TR_NONSEQ: begin
        case (hburst)
          3'd2, 3'd3: beat_next = 5'd3;
          3'd4, 3'd5: beat_next = 5'd7;
          3'd6, 3'd7: beat_next = 5'd15;
          default:    beat_next = 5'd0;
        endcase
      end
      TR_SEQ:  if (beat_cnt != 5'd0) beat_next = beat_cnt - 5'd1;
      TR_BUSY: beat_next = beat_cnt;
      default: beat_next = 5'd0;
    endcase
  end

  // The bus may change hands when the presented transfer ends a burst; INCR is always interruptible
  always_comb begin
    burst_done = ((htrans == TR_IDLE || htrans == TR_BUSY) && beat_cnt == 5'd0)
              || (htrans == TR_NONSEQ && (hburst == BU_SINGLE || hburst == BU_INCR))
              || (htrans == TR_SEQ && (beat_cnt <= 5'd1 || hburst == BU_INCR));
  end

  assign rearb_ok = hready & ~lock_active & burst_done;

  // Winner selection: first pass looks above rr_ptr (round-robin only), second pass wraps around
  always_comb begin
    winner = DEF_IDX;
    found  = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (!found && hbusreq[i] && (ARB_MODE == 0 || HMASTER_W'(i) > rr_ptr)) begin
        winner = HMASTER_W'(i);
        found  = 1'b1;
      end
    end
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (!found && hbusreq[i]) begin
        winner = HMASTER_W'(i);
        found  = 1'b1;
      end
    end
  end

  // Owner, lock, beat and grant state; everything freezes while hready is low.
  // lock_hold remembers that the owner's hlock was high at the last accepted transfer,
  // so once hlock drops the grant survives exactly one more transfer.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      hgrant    <= DEF_GRANT;
      hmaster   <= DEF_IDX;
      hmastlock <= 1'b0;
      beat_cnt  <= 5'd0;
      lock_hold <= 1'b0;
      rr_ptr    <= DEF_IDX;
    end else if (hready) begin
      hmaster   <= grant_idx;
      hmastlock <= owner_lock;
      beat_cnt  <= beat_next;
      lock_hold <= owner_lock;
      if (rearb_ok) begin
        hgrant <= NUM_MASTERS'(1) << winner;
        if (ARB_MODE != 0 && any_req) rr_ptr <= winner;
      end
    end
  end

endmodule
